// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Purpose  : 4x4 active-low key matrix scanner. Drives one column low at a
//            time, samples the synchronised rows, debounces whole scans and
//            decodes the result into a key code with press/release events.
// Options  : KEYPAD_AUTOREPEAT_EN - when defined, key_valid re-pulses while a
//            key is held (REPEAT_DELAY scans, then every REPEAT_RATE scans).
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEB_SCANS    = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down,
    output logic       key_release
);

    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DEB_W = $clog2(DEB_SCANS + 1);

    // Scan result kinds; NONE and MULTI carry a zero code so that a plain
    // equality compare of {kind, code} is a correct "same result" test.
    localparam logic [1:0] c_RES_NONE   = 2'd0;
    localparam logic [1:0] c_RES_SINGLE = 2'd1;
    localparam logic [1:0] c_RES_MULTI  = 2'd2;

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_PRESSED = 1'b1;

    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [c_PRE_W-1:0] r_presc;
    logic [1:0]         r_col_idx;
    logic [3:0]         r_col;
    logic [1:0]         r_acc_hits;
    logic [3:0]         r_acc_code;
    logic               r_acc_multi;
    logic [5:0]         r_cand;
    logic [c_DEB_W-1:0] r_stable_cnt;
    logic [0:0]         r_state;
    logic [3:0]         r_key;
    logic               r_key_valid;
    logic               r_key_down;
    logic               r_key_release;

    logic               w_tick;
    logic               w_scan_end;
    logic [3:0]         w_row_low;
    logic [2:0]         w_low_cnt;
    logic [1:0]         w_row_idx;
    logic               w_col_one;
    logic               w_col_multi;
    logic [1:0]         w_hits_nxt;
    logic [3:0]         w_code_nxt;
    logic               w_multi_nxt;
    logic [5:0]         w_result;
    logic               w_same;
    logic               w_stable;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_first;
    logic [c_REP_W-1:0] w_rep_nxt;
    logic [c_REP_W-1:0] w_rep_target;

    assign w_rep_nxt    = r_rep_cnt + c_REP_W'(1);
    assign w_rep_target = r_rep_first ? c_REP_W'(REPEAT_DELAY) : c_REP_W'(REPEAT_RATE);
`else
    logic w_unused_rep;
    assign w_unused_rep = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

    assign w_tick     = (r_presc == c_PRE_W'(SCAN_DIV - 1));
    assign w_scan_end = w_tick && (r_col_idx == 2'd3);

    // Two-flop synchroniser for the asynchronous row inputs (idle = all high)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    // Scan prescaler and one-cold column rotation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_col_idx <= 2'd0;
            r_col     <= 4'b1110;
        end else if (w_tick) begin
            r_presc   <= '0;
            r_col_idx <= r_col_idx + 2'd1;
            r_col     <= {r_col[2:0], r_col[3]};
        end else begin
            r_presc   <= r_presc + c_PRE_W'(1);
        end
    end

    // Count the low rows of the current column and remember which one it was
    always_comb begin
        w_row_low = ~r_row_sync;
        w_low_cnt = 3'd0;
        w_row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_row_low[i]) begin
                w_low_cnt = w_low_cnt + 3'd1;
                w_row_idx = 2'(i);
            end
        end
    end

    // Fold the current column into the scan accumulators and classify the scan
    always_comb begin
        w_col_one   = (w_low_cnt == 3'd1);
        w_col_multi = (w_low_cnt >= 3'd2);
        w_hits_nxt  = r_acc_hits;
        w_code_nxt  = r_acc_code;
        if (w_col_one) begin
            w_code_nxt = {w_row_idx, r_col_idx};
            if (r_acc_hits != 2'd2) begin
                w_hits_nxt = r_acc_hits + 2'd1;
            end
        end
        w_multi_nxt = r_acc_multi | w_col_multi;
        if (w_multi_nxt || (w_hits_nxt == 2'd2)) begin
            w_result = {c_RES_MULTI, 4'd0};
        end else if (w_hits_nxt == 2'd1) begin
            w_result = {c_RES_SINGLE, w_code_nxt};
        end else begin
            w_result = {c_RES_NONE, 4'd0};
        end
    end

    // A result is stable on the scan where its run length first hits DEB_SCANS
    always_comb begin
        w_same   = (w_result == r_cand);
        w_stable = w_same ? (r_stable_cnt == c_DEB_W'(DEB_SCANS - 1)) : (DEB_SCANS == 1);
    end

    // Per-scan hit accumulators, cleared when the scan result is formed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_hits  <= 2'd0;
            r_acc_code  <= 4'd0;
            r_acc_multi <= 1'b0;
        end else if (w_scan_end) begin
            r_acc_hits  <= 2'd0;
            r_acc_code  <= 4'd0;
            r_acc_multi <= 1'b0;
        end else if (w_tick) begin
            r_acc_hits  <= w_hits_nxt;
            r_acc_code  <= w_code_nxt;
            r_acc_multi <= w_multi_nxt;
        end
    end

    // Debounce candidate and saturating run-length counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand       <= {c_RES_NONE, 4'd0};
            r_stable_cnt <= '0;
        end else if (w_scan_end) begin
            if (w_same) begin
                if (r_stable_cnt != c_DEB_W'(DEB_SCANS)) begin
                    r_stable_cnt <= r_stable_cnt + c_DEB_W'(1);
                end
            end else begin
                r_cand       <= w_result;
                r_stable_cnt <= c_DEB_W'(1);
            end
        end
    end

    // Press/release state machine with registered key outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_key         <= 4'd0;
            r_key_valid   <= 1'b0;
            r_key_down    <= 1'b0;
            r_key_release <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt     <= '0;
            r_rep_first   <= 1'b1;
`endif
        end else begin
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            if (w_scan_end) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_stable && (w_result[5:4] == c_RES_SINGLE)) begin
                            r_state     <= c_ST_PRESSED;
                            r_key       <= w_result[3:0];
                            r_key_down  <= 1'b1;
                            r_key_valid <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            r_rep_cnt   <= '0;
                            r_rep_first <= 1'b1;
`endif
                        end
                    end
                    c_ST_PRESSED: begin
                        // Only a stable empty scan releases; other keys are ignored
                        if (w_stable && (w_result[5:4] == c_RES_NONE)) begin
                            r_state       <= c_ST_IDLE;
                            r_key_down    <= 1'b0;
                            r_key_release <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            r_rep_cnt     <= '0;
                            r_rep_first   <= 1'b1;
`endif
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        else if (w_rep_nxt == w_rep_target) begin
                            r_key_valid <= 1'b1;
                            r_rep_cnt   <= '0;
                            r_rep_first <= 1'b0;
                        end else begin
                            r_rep_cnt   <= w_rep_nxt;
                        end
`endif
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign col         = r_col;
    assign key         = r_key;
    assign key_valid   = r_key_valid;
    assign key_down    = r_key_down;
    assign key_release = r_key_release;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan
// Purpose  : Self-checking bench for keypad_scan. A key-set mask drives the
//            matrix rows from the DUT columns; a scan-level model predicts
//            every output on every clock. Honours KEYPAD_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

    localparam int c_SCAN_DIV = 4;
    localparam int c_DEB      = 2;
    localparam int c_RD       = 3;
    localparam int c_RR       = 2;
    localparam int c_SCAN_CLK = 4 * c_SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_down;
    logic        key_release;
    logic [15:0] mask = 16'h0;

    int n_vec = 0;
    int n_err = 0;

    // Model state: run length of identical scan results since reset
    int          m_run;
    logic [5:0]  m_prev;
    logic        m_pressed;
    logic [3:0]  m_key;
    int          m_since;
    logic        m_valid;
    logic        m_rel;

    keypad_scan #(
        .SCAN_DIV    (c_SCAN_DIV),
        .DEB_SCANS   (c_DEB),
        .REPEAT_DELAY(c_RD),
        .REPEAT_RATE (c_RR)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .key        (key),
        .key_valid  (key_valid),
        .key_down   (key_down),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (mask[r*4+c]) row[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t {col,key,valid,down,release} got=%b expected=%b",
                     tag, $time, got, exp);
        end
    endtask

    // Scan outcome from the key set: 0x00 none, {01,code} single, 0x20 multi
    function automatic logic [5:0] scan_result(input logic [15:0] m);
        int   singles;
        int   n;
        int   rr;
        logic multi;
        logic [3:0] code;
        singles = 0;
        multi   = 1'b0;
        code    = 4'd0;
        rr      = 0;
        for (int c = 0; c < 4; c++) begin
            n = 0;
            for (int r = 0; r < 4; r++) begin
                if (m[r*4+c]) begin
                    n++;
                    rr = r;
                end
            end
            if (n == 1) begin
                singles++;
                code = 4'(rr * 4 + c);
            end
            if (n >= 2) multi = 1'b1;
        end
        if (multi || singles > 1) return 6'h20;
        if (singles == 1) return {2'b01, code};
        return 6'h00;
    endfunction

    task automatic model_reset();
        m_run     = 0;
        m_prev    = 6'h00;
        m_pressed = 1'b0;
        m_key     = 4'd0;
        m_since   = 0;
        m_valid   = 1'b0;
        m_rel     = 1'b0;
    endtask

    task automatic model_scan(input logic [15:0] m);
        logic [5:0] res;
        logic       stable;
        res = scan_result(m);
        if (m_run > 0 && res == m_prev) m_run++;
        else begin
            m_prev = res;
            m_run  = 1;
        end
        stable = (m_run == c_DEB);
        if (!m_pressed) begin
            if (stable && res[5:4] == 2'b01) begin
                m_pressed = 1'b1;
                m_key     = res[3:0];
                m_valid   = 1'b1;
                m_since   = 0;
            end
        end else if (stable && res == 6'h00) begin
            m_pressed = 1'b0;
            m_rel     = 1'b1;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            m_since++;
            if (m_since == c_RD || (m_since > c_RD && (m_since - c_RD) % c_RR == 0))
                m_valid = 1'b1;
`endif
        end
    endtask

    // Run one scan (or the first ncyc clocks of one) with a fixed key set
    task automatic run_scan(input logic [15:0] m, input int ncyc, input string tag);
        logic [3:0] exp_col;
        mask = m;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            m_valid = 1'b0;
            m_rel   = 1'b0;
            if (k == c_SCAN_CLK) model_scan(m);
            exp_col = ~(4'b0001 << ((k / c_SCAN_DIV) % 4));
            chk(tag, {col, key, key_valid, key_down, key_release},
                {exp_col, m_key, m_valid, m_pressed, m_rel});
        end
    endtask

    task automatic scans(input logic [15:0] m, input int n, input string tag);
        for (int s = 0; s < n; s++) run_scan(m, c_SCAN_CLK, tag);
    endtask

    task automatic do_reset(input logic [15:0] m);
        mask = m;
        rst  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset", {col, key, key_valid, key_down, key_release}, {4'b1110, 4'd0, 3'b000});
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] cur;
        int          p;
        int          a;
        int          b;
        model_reset();
        do_reset(16'h0);

        // Single press of key 9 (row 2, col 1), then release
        scans(16'h0200, 5, "press9");
        scans(16'h0000, 4, "release9");

        // Bounce on key 5, then a stable hold and release
        for (int s = 0; s < 6; s++) run_scan((s % 2 == 0) ? 16'h0020 : 16'h0000, c_SCAN_CLK, "bounce5");
        scans(16'h0020, 4, "hold5");
        scans(16'h0000, 3, "release5");

        // Ghost pair from idle, then a second key added while held
        scans(16'h8001, 4, "ghost");
        scans(16'h0000, 2, "ghost_off");
        scans(16'h0008, 4, "press3");
        scans(16'h1008, 4, "add12");
        scans(16'h0000, 3, "release3");

        // Rollover blocked
        scans(16'h0008, 4, "hold3");
        scans(16'h0080, 4, "roll7");
        scans(16'h0000, 3, "rel_all");
        scans(16'h0080, 4, "press7");
        scans(16'h0000, 3, "release7");

        // Long hold of key 1, then reset mid-scan while still held
        scans(16'h0002, 10, "hold1");
        run_scan(16'h0002, 7, "hold1_part");
        do_reset(16'h0000);
        scans(16'h0000, 2, "post_reset");

        // Randomised key activity with occasional mid-scan resets
        cur = 16'h0;
        for (int s = 0; s < 160; s++) begin
            p = $urandom_range(0, 99);
            if (p < 40) begin
                cur = cur;
            end else if (p < 65) begin
                cur = 16'h0;
            end else if (p < 90) begin
                cur = 16'h1 << $urandom_range(0, 15);
            end else begin
                a   = $urandom_range(0, 15);
                b   = $urandom_range(0, 15);
                cur = (16'h1 << a) | (16'h1 << b);
            end
            if ($urandom_range(0, 39) == 0) begin
                run_scan(cur, $urandom_range(1, c_SCAN_CLK - 1), "rand_part");
                do_reset(cur);
            end else begin
                run_scan(cur, c_SCAN_CLK, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
